// File: rtl/fmap_pkg.sv
// ---------------------------------------------------------------------------
// fmap_pkg
//   Shared definitions for the feature-map path of the CSP/CBS conv chain.
//   - DATA_WIDTH / FMAP_D / FMAP_H / FMAP_W : default element width and frame
//     geometry used by every stage.
//   - elem_index(d, h, w) : flat, channel-major element number within a frame.
//   - frame_bits(d, h, w, dw) : width of the flat frame bus, used for port
//     sizing by the loader and the conv stages.
// ---------------------------------------------------------------------------
package fmap_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FMAP_D     = 3;
    localparam int FMAP_H     = 4;
    localparam int FMAP_W     = 4;

    // Channel-major ordering: d is the slowest index, w the fastest.
    function automatic int elem_index(input int d, input int h, input int w);
        return d * FMAP_H * FMAP_W + h * FMAP_W + w;
    endfunction

    function automatic int frame_bits(input int d, input int h, input int w,
                                      input int dw);
        return d * h * w * dw;
    endfunction

endpackage

// File: rtl/fmap_bank.sv
// ---------------------------------------------------------------------------
// fmap_bank
//   One frame buffer of N elements, each DATA_WIDTH bits, presented as a flat
//   vector with element 0 at the MSB end.
//   Ports:
//     clk    : clock, all state on rising edge
//     reset  : synchronous active-low clear of the whole frame
//     we     : write one element this cycle
//     idx    : element number to write (0..N-1)
//     wdata  : element value
//     q      : whole frame, element i at bits [(N-1-i)*DATA_WIDTH +: DATA_WIDTH]
// ---------------------------------------------------------------------------
module fmap_bank #(
    parameter  int DATA_WIDTH = 16,
    parameter  int N          = 48,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [N*DATA_WIDTH-1:0] q
);

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking assignments here would create ordering races.
    // NOTE: this storage is deliberately reset: the frame bus must read as all
    // zeros after reset, so it cannot be left as an unreset RAM-style array.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (we) begin
            q[(N - 1 - int'(idx)) * DATA_WIDTH +: DATA_WIDTH] <= wdata;
        end
    end

endmodule

// File: rtl/fmap_stream_loader.sv
// ---------------------------------------------------------------------------
// fmap_stream_loader
//   Upstream input stage of the conv chain. Collects one element per beat from
//   a valid/ready stream (channel-major: d, h, w) into a ping-pong pair of
//   frame banks and presents each completed frame on the flat bus x until the
//   consumer acknowledges it.
//   Ports:
//     clk       : clock, all state on rising edge
//     reset     : synchronous active-low reset
//     in_data   : stream element
//     in_valid  : in_data valid
//     in_sof    : start of frame, meaningful only on an accepted beat
//     in_ready  : a beat can be accepted this cycle
//     x         : flat frame, [0:...] ordering, element 0 in x[0 +: DATA_WIDTH]
//     out_valid : x holds a complete frame
//     out_ack   : consumer has taken the frame (ignored while out_valid=0)
//     sof_err   : one-cycle pulse, a partial frame was abandoned by in_sof
// ---------------------------------------------------------------------------
module fmap_stream_loader
    import fmap_pkg::*;
#(
    parameter int DATA_WIDTH = fmap_pkg::DATA_WIDTH,
    parameter int D          = FMAP_D,
    parameter int H          = FMAP_H,
    parameter int W          = FMAP_W
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [DATA_WIDTH-1:0]                      in_data,
    input  logic                                       in_valid,
    input  logic                                       in_sof,
    output logic                                       in_ready,
    output logic [0:frame_bits(D, H, W, DATA_WIDTH)-1] x,
    output logic                                       out_valid,
    input  logic                                       out_ack,
    output logic                                       sof_err
);

    localparam int N     = D * H * W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        base_idx;
    logic [CNT_W-1:0]        cnt_next;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [1:0]              full;
    logic                    accept;
    logic                    frame_done;
    logic                    ack_take;
    logic                    sof_err_next;
    logic [1:0]              bank_we;
    logic [N*DATA_WIDTH-1:0] bank_q [2];

    // The filling bank is always the one not flagged full, so a free filling
    // bank is exactly the condition for taking another beat.
    assign in_ready  = reset & ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign x         = bank_q[rd_bank];

    // NOTE: every signal driven here gets a value on every path through the
    // block; a missing assignment would silently infer a latch.
    always_comb begin
        accept       = in_valid & in_ready;
        // in_sof forces the beat to element 0 regardless of where cnt is.
        base_idx     = in_sof ? '0 : cnt;
        frame_done   = accept & (base_idx == CNT_LAST);
        cnt_next     = frame_done ? '0 : base_idx + CNT_W'(1);
        sof_err_next = accept & in_sof & (cnt != '0);
        ack_take     = out_ack & full[rd_bank];
        bank_we      = {accept & wr_bank, accept & ~wr_bank};
    end

    // Completion always targets full[wr_bank] and ack always full[rd_bank];
    // when both happen in one cycle they are different banks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
            sof_err <= 1'b0;
        end else begin
            sof_err <= sof_err_next;
            if (accept) begin
                cnt <= cnt_next;
                if (frame_done) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (ack_take) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fmap_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (bank_we[b]),
            .idx   (base_idx),
            .wdata (in_data),
            .q     (bank_q[b])
        );
    end

endmodule

// File: tb/tb_fmap_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_fmap_stream_loader
//   Self-checking bench for fmap_stream_loader (D=3, H=4, W=4, 16-bit data).
//   The reference model keeps the partial frame and the undelivered frames as
//   plain element queues; a frame is visible on x once all N elements arrived.
// ---------------------------------------------------------------------------
module tb_fmap_stream_loader;

    localparam int DW = 16;
    localparam int N  = 48;
    localparam int FB = N * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [0:FB-1] x;
    logic          out_valid;
    logic          out_ack;
    logic          sof_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] cur[$];   // elements of the frame being received
    logic [DW-1:0] pend[$];  // completed, not yet acknowledged frames, oldest first
    bit            exp_sof_err = 1'b0;

    always #5 clk = ~clk;

    fmap_stream_loader #(
        .DATA_WIDTH (DW),
        .D          (3),
        .H          (4),
        .W          (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .sof_err   (sof_err)
    );

    // Two frames of storage: room for another beat while fewer than two
    // complete frames are waiting.
    function automatic bit exp_ready();
        return reset && (pend.size() < 2 * N);
    endfunction

    function automatic bit exp_valid();
        return pend.size() >= N;
    endfunction

    // Oldest pending frame laid out on the bus by element number.
    function automatic logic [0:FB-1] exp_x();
        logic [0:FB-1] v;
        int            i;
        v = '0;
        for (int d = 0; d < 3; d++)
            for (int h = 0; h < 4; h++)
                for (int w = 0; w < 4; w++) begin
                    i = fmap_pkg::elem_index(d, h, w);
                    v[i*DW +: DW] = pend[i];
                end
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, and leave
    // time 1 unit after the edge for sampling.
    task automatic tick(input bit v, input bit sof, input logic [DW-1:0] d,
                        input bit ack);
        bit acc;
        bit take;
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        out_ack  = ack;
        acc      = v && exp_ready();
        take     = ack && exp_valid();
        @(posedge clk);
        if (!reset) begin
            cur.delete();
            pend.delete();
            exp_sof_err = 1'b0;
        end else begin
            exp_sof_err = acc && sof && (cur.size() != 0);
            if (take) repeat (N) void'(pend.pop_front());
            if (acc) begin
                if (sof) cur.delete();
                cur.push_back(d);
                if (cur.size() == N) begin
                    foreach (cur[k]) pend.push_back(cur[k]);
                    cur.delete();
                end
            end
        end
        #1;
    endtask

    // Offer a beat until accepted; ack (if requested) only on the first cycle.
    task automatic send_beat(input logic [DW-1:0] d, input bit sof, input bit ack);
        bit r;
        for (int t = 0; t < 64; t++) begin
            r = exp_ready();
            tick(1'b1, sof, d, (t == 0) ? ack : 1'b0);
            if (r) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL send_beat_timeout: beat %h not accepted within 64 cycles", d);
    endtask

    task automatic drain();
        for (int t = 0; t < 4; t++)
            if (exp_valid()) tick(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (x !== '0) begin
            miscompares++; $display("FAIL reset_x: got %h expected 0", x);
        end
        vectors++;
        if (sof_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_sof_err: got %b expected 0", sof_err);
        end
        reset = 1'b1;
        tick(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < N; i++) begin
            tick(1'b1, i == 0, DW'(i), 1'b0);
            vectors++;
            if (out_valid !== exp_valid()) begin
                miscompares++;
                $display("FAIL single_out_valid beat %0d: got %b expected %b", i, out_valid, exp_valid());
            end
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++; $display("FAIL single_in_ready beat %0d: got %b expected 1", i, in_ready);
            end
        end
        vectors++;
        if (x[0 +: DW] !== 16'h0000) begin
            miscompares++; $display("FAIL single_first_elem: got %h expected 0000", x[0 +: DW]);
        end
        vectors++;
        if (x[752 +: DW] !== 16'h002F) begin
            miscompares++; $display("FAIL single_last_elem: got %h expected 002f", x[752 +: DW]);
        end
        vectors++;
        if (x !== exp_x()) begin
            miscompares++; $display("FAIL single_frame: got %h expected %h", x, exp_x());
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_ack_out_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        for (int f = 1; f <= 2; f++)
            for (int i = 0; i < N; i++)
                send_beat(DW'(16'h1000 * f + i), i == 0, 1'b0);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL b2b_full_in_ready: got %b expected 0", in_ready);
        end
        vectors++;
        if (x[0 +: DW] !== 16'h1000) begin
            miscompares++; $display("FAIL b2b_frame1: got %h expected 1000", x[0 +: DW]);
        end
        // Frame 3 is offered but must stall.
        for (int t = 0; t < 3; t++) begin
            tick(1'b1, 1'b1, 16'h3000, 1'b0);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++; $display("FAIL b2b_stall_in_ready: got %b expected 0", in_ready);
            end
        end
        tick(1'b1, 1'b1, 16'h3000, 1'b1);
        vectors++;
        if (x[0 +: DW] !== 16'h2000) begin
            miscompares++; $display("FAIL b2b_switch_frame2: got %h expected 2000", x[0 +: DW]);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_after_ack_in_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < N; i++) send_beat(DW'(16'h3000 + i), i == 0, 1'b0);
        vectors++;
        if (x !== exp_x()) begin
            miscompares++; $display("FAIL b2b_frame2_held: got %h expected %h", x, exp_x());
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (x[0 +: DW] !== 16'h3000 || x !== exp_x()) begin
            miscompares++; $display("FAIL b2b_frame3: got %h expected %h", x, exp_x());
        end
        drain();
    endtask

    task automatic test_sof_restart();
        int            pulses;
        int            orphans;
        logic [DW-1:0] e;
        pulses  = 0;
        orphans = 0;
        drain();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, i == 0, DW'(16'h5000 + i), 1'b0);
            pulses += int'(sof_err);
        end
        tick(1'b1, 1'b1, 16'hAAAA, 1'b0);
        pulses += int'(sof_err);
        vectors++;
        if (sof_err !== 1'b1) begin
            miscompares++; $display("FAIL sof_err_timing: got %b expected 1", sof_err);
        end
        for (int i = 0; i < N - 1; i++) begin
            tick(1'b1, 1'b0, DW'(16'h6000 + i), 1'b0);
            pulses += int'(sof_err);
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++; $display("FAIL sof_err_count: got %0d expected 1", pulses);
        end
        vectors++;
        if (x[0 +: DW] !== 16'hAAAA) begin
            miscompares++; $display("FAIL sof_first_elem: got %h expected aaaa", x[0 +: DW]);
        end
        for (int i = 0; i < N; i++) begin
            e = x[i*DW +: DW];
            if (e >= 16'h5000 && e < 16'h5014) orphans++;
        end
        vectors++;
        if (orphans !== 0) begin
            miscompares++; $display("FAIL sof_orphans: got %0d expected 0", orphans);
        end
        vectors++;
        if (out_valid !== 1'b1 || x !== exp_x()) begin
            miscompares++; $display("FAIL sof_frame: got %h expected %h", x, exp_x());
        end
        drain();
    endtask

    task automatic test_ack_collision();
        drain();
        for (int i = 0; i < N; i++) tick(1'b1, i == 0, DW'(16'hA000 + i), 1'b0);
        for (int i = 0; i < N - 1; i++) tick(1'b1, i == 0, DW'(16'hB000 + i), 1'b0);
        tick(1'b1, 1'b0, 16'hB02F, 1'b1);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL collide_out_valid: got %b expected 1", out_valid);
        end
        vectors++;
        if (x[0 +: DW] !== 16'hB000 || x[752 +: DW] !== 16'hB02F) begin
            miscompares++; $display("FAIL collide_frame_b: got %h/%h expected b000/b02f", x[0 +: DW], x[752 +: DW]);
        end
        vectors++;
        if (x !== exp_x()) begin
            miscompares++; $display("FAIL collide_frame: got %h expected %h", x, exp_x());
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL collide_no_dup: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] e0;
        drain();
        for (int i = 0; i < N; i++) tick(1'b1, i == 0, DW'(16'hC000 + i), 1'b0);
        for (int i = 0; i < 30; i++) tick(1'b1, i == 0, DW'(16'hD000 + i), 1'b0);
        reset = 1'b0;
        repeat (2) tick(1'b1, 1'b0, 16'hD0FF, 1'b0);
        vectors++;
        if (x !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: got x=%h out_valid=%b in_ready=%b expected 0/0/0", x, out_valid, in_ready);
        end
        reset = 1'b1;
        tick(1'b0, 1'b0, '0, 1'b0);
        e0 = DW'($urandom);
        for (int i = 0; i < N; i++) tick(1'b1, 1'b0, (i == 0) ? e0 : DW'($urandom), 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || x[0 +: DW] !== e0) begin
            miscompares++;
            $display("FAIL midreset_fresh: got valid=%b elem0=%h expected 1/%h", out_valid, x[0 +: DW], e0);
        end
        vectors++;
        if (x !== exp_x()) begin
            miscompares++; $display("FAIL midreset_frame: got %h expected %h", x, exp_x());
        end
        drain();
    endtask

    task automatic test_random();
        bit v;
        bit sof;
        bit ack;
        // Stray acks with nothing to deliver.
        for (int t = 0; t < 3; t++) begin
            tick(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stray_ack: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
            end
        end
        for (int c = 0; c < 2000; c++) begin
            v   = $urandom_range(0, 3) != 0;
            sof = $urandom_range(0, 63) == 0;
            ack = (c < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            tick(v, sof, DW'($urandom), ack);
            vectors++;
            if (in_ready !== exp_ready()) begin
                miscompares++; $display("FAIL rand_in_ready cyc %0d: got %b expected %b", c, in_ready, exp_ready());
            end
            vectors++;
            if (out_valid !== exp_valid()) begin
                miscompares++; $display("FAIL rand_out_valid cyc %0d: got %b expected %b", c, out_valid, exp_valid());
            end
            vectors++;
            if (sof_err !== exp_sof_err) begin
                miscompares++; $display("FAIL rand_sof_err cyc %0d: got %b expected %b", c, sof_err, exp_sof_err);
            end
            if (exp_valid()) begin
                vectors++;
                if (x !== exp_x()) begin
                    miscompares++; $display("FAIL rand_x cyc %0d: got %h expected %h", c, x, exp_x());
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        out_ack  = 1'b0;
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_sof_restart();
        test_ack_collision();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fmap_stream_loader.md
Name: fmap_stream_loader

Overview:
- Upstream input stage for the CSP/CBS conv chain.
- Accepts one feature-map element per beat on a valid/ready stream, in channel-major order (d, then h, then w).
- Assembles each complete frame into the flat bus the conv stages consume, x[0:D*H*W*DATA_WIDTH-1].
- Ping-pong buffered: one frame is filled while the previous one is held stable on the output until the consumer acknowledges it.

Parameters:
DATA_WIDTH, 16, element width in bits (FP16 pattern, treated as opaque bits)
D, 3, channel depth of the frame
H, 4, frame height
W, 4, frame width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low reset
in_data  input  DATA_WIDTH  stream element
in_valid  input  1  in_data valid
in_sof  input  1  start of frame; meaningful only on an accepted beat
in_ready  output  1  loader can accept a beat this cycle
x  output  D*H*W*DATA_WIDTH  flat frame, [0:...] ordering, feeds the conv stage x input
out_valid  output  1  x holds a complete frame
out_ack  input  1  consumer has taken the frame; honoured only when out_valid=1
sof_err  output  1  one-cycle pulse: a frame was restarted early by in_sof

Behaviour:
- Constants: N = D*H*W. Element i = d*H*W + h*W + w occupies x[i*DATA_WIDTH +: DATA_WIDTH], i.e. element 0 is at the MSB end.
- State:
  - Two banks, bank[0] and bank[1], each N*DATA_WIDTH bits.
  - full[1:0] flags.
  - wr_bank and rd_bank selects.
  - Element counter cnt, 0..N-1, width $clog2(N).
- Reset (reset==0 at a clock edge) clears:
  - cnt, wr_bank, rd_bank, full and sof_err to 0.
  - Both banks to 0, so x=0 and out_valid=0.
  - While reset is low, in_ready=0.
  - Reset mid-frame discards the partial frame and any held frame. No output pulses are generated for them.
- in_ready = reset & ~full[wr_bank] (combinational). A beat is accepted when in_valid & in_ready.
- Accepted beat, in_sof=0:
  - in_data is written to bank[wr_bank] element cnt.
  - If cnt==N-1: cnt<=0, full[wr_bank]<=1, wr_bank toggles.
  - Otherwise cnt<=cnt+1.
- Accepted beat, in_sof=1:
  - The beat is written to element 0 and cnt<=1.
  - If cnt!=0 beforehand, the partial frame is abandoned and sof_err pulses 1 on the next cycle.
  - in_sof with cnt==0 is normal and raises no error.
  - Edge case N=1: the in_sof beat completes the frame immediately (cnt<=0, full set).
- An out-of-frame beat with in_sof=0 and cnt==0 is accepted as element 0. in_sof is optional for the first frame.
- Output side:
  - out_valid = full[rd_bank]; x = bank[rd_bank].
  - On out_ack & out_valid: full[rd_bank]<=0 and rd_bank toggles.
  - out_ack while out_valid=0 is ignored.
- Latency:
  - Last beat accepted at edge T → out_valid=1 after edge T, provided that bank is rd_bank.
  - Otherwise out_valid rises the cycle after the older frame is acked.
- Throughput: one beat per cycle sustained while the consumer acks within N cycles.
- Simultaneous events:
  - Frame completion on wr_bank and ack on rd_bank in the same cycle are independent and both take effect.
  - The filling bank is never full, so completion and ack never target the same flag.
  - Both banks full → in_ready=0 until an ack. The ack frees a bank, and in_ready=1 on the following cycle.
- x is stable (no bit changes) while out_valid=1 and no ack is presented.
- Data are never modified, only positioned.

Decomposition:
- Shared package fmap_pkg holds:
  - DATA_WIDTH.
  - A function elem_index(d,h,w) = d*H*W + h*W + w.
  - A frame-bits helper (D*H*W*DATA_WIDTH), reused by the CBS/CSP stages for port sizing.
- One sub-module, fmap_bank:
  - Holds one N*DATA_WIDTH register, with synchronous active-low clear.
  - Write enable plus element index writes DATA_WIDTH bits.
  - Instantiated twice.
- The top level holds cnt, the select flags and the handshake logic.

Test Plan (default D=3,H=4,W=4, N=48):
1. Reset, then 48 beats with in_data=i (0..47), in_sof on beat 0, out_ack held 0 → out_valid=1 the cycle after beat 47; x[0:15]=16'h0000, x[752:767]=16'h002F; in_ready stays 1.
2. Stream 3 frames back-to-back (values 16'h1000+i, 16'h2000+i, 16'h3000+i) with out_ack=0 → after frame 2, in_ready=0 and frame 3 stalls. Pulse out_ack → x switches to frame 2 (x[0:15]=16'h2000); in_ready=1 the next cycle; frame 3 then completes.
3. Send 20 beats, then an in_sof beat with data 16'hAAAA, then 47 more beats → sof_err pulses exactly once, one cycle after the in_sof beat; the delivered frame has x[0:15]=16'hAAAA and contains none of the 20 orphan values.
4. Last beat of frame B accepted in the same cycle as out_ack of frame A → the next cycle shows out_valid=1 with x = frame B and no lost or duplicated frame.
5. Assert reset low at beat 30 of a frame while another frame is held → x=0, out_valid=0, in_ready=0 during reset. After release, a fresh 48-beat frame is delivered correctly.
6. out_ack pulses while out_valid=0, and random in_valid gaps → no state change on the stray acks; frame contents match a scoreboard keyed on elem_index.
